// File: rtl/responder_pkg.sv
// Shared types and constants for the quiz responder.
// Contents:
//   timer_state_t - countdown timer FSM states.
//   bcd_digit_t   - one 4-bit BCD digit.
//   BCD_MAX       - largest legal BCD digit value (9).
//   bcd_to_bin    - converts a two-digit BCD value to binary (0..99).
package responder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    EXPIRED
  } timer_state_t;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;

  function automatic logic [6:0] bcd_to_bin(input bcd_digit_t tens, input bcd_digit_t ones);
    return (7'(tens) * 7'd10) + 7'(ones);
  endfunction

endpackage

// File: rtl/tick_gen.sv
// One-second prescaler for the answer timer.
// Ports:
//   clk   - system clock.
//   rst_n - synchronous active-low reset.
//   en    - advance the prescaler this cycle.
//   clr   - force the prescaler to 0 (takes priority over en).
//   tick  - high while the prescaler holds its terminal count CLK_HZ-1.
//           It is deliberately not gated by en, so the caller can let
//           a terminal count fire even when it otherwise holds the count.
module tick_gen #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_HZ - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick = (cnt_q == CNT_MAX);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/answer_timer.sv
// Answer countdown timer for the quiz responder.
// Counts seconds down from START_SEC in BCD while Timer_Start is high,
// freezes while it is low, and locks out the select stage on expiry.
// Ports:
//   CLK           - system clock (single domain).
//   RSTn          - synchronous active-low reset.
//   Timer_Start   - level: 1 = count, 0 = hold.
//   Block_Sel     - 1 once time has expired (held until reset).
//   Sec_Tens      - BCD tens digit of remaining seconds.
//   Sec_Ones      - BCD ones digit of remaining seconds.
//   Timeout_Pulse - one-cycle strobe on the expiry edge.
//   Warn          - high while counting/paused with 1..WARN_SEC seconds left.
// All outputs are registered.
module answer_timer
  import responder_pkg::*;
#(
  parameter int CLK_HZ    = 50_000_000,
  parameter int START_SEC = 30,
  parameter int WARN_SEC  = 5
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       Timer_Start,
  output logic       Block_Sel,
  output logic [3:0] Sec_Tens,
  output logic [3:0] Sec_Ones,
  output logic       Timeout_Pulse,
  output logic       Warn
);

  localparam bcd_digit_t START_TENS = bcd_digit_t'(START_SEC / 10);
  localparam bcd_digit_t START_ONES = bcd_digit_t'(START_SEC % 10);
  localparam logic [6:0] WARN_VAL   = 7'(WARN_SEC);

  timer_state_t state_q, state_d;
  bcd_digit_t   tens_q, tens_d;
  bcd_digit_t   ones_q, ones_d;
  logic         block_q, block_d;
  logic         pulse_q, pulse_d;
  logic         warn_q, warn_d;
  logic [6:0]   val_d;

  logic pre_en;
  logic pre_clr;
  logic pre_tick;

  tick_gen #(
    .CLK_HZ(CLK_HZ)
  ) u_tick_gen (
    .clk  (CLK),
    .rst_n(RSTn),
    .en   (pre_en),
    .clr  (pre_clr),
    .tick (pre_tick)
  );

  always_comb begin
    state_d = state_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    pre_en  = 1'b0;
    pre_clr = 1'b0;

    unique case (state_q)
      IDLE: begin
        pre_clr = 1'b1;
        tens_d  = START_TENS;
        ones_d  = START_ONES;
        if (Timer_Start) begin
          state_d = RUN;
        end
      end

      RUN: begin
        // A terminal count still fires (and wraps the prescaler) in the
        // cycle Timer_Start drops; otherwise a low Timer_Start freezes it.
        pre_en = Timer_Start || pre_tick;
        if (pre_tick) begin
          if (ones_q != 4'd0) begin
            ones_d = ones_q - bcd_digit_t'(1);
          end else if (tens_q != 4'd0) begin
            ones_d = BCD_MAX;
            tens_d = tens_q - bcd_digit_t'(1);
          end
          if ((tens_d == 4'd0) && (ones_d == 4'd0)) begin
            state_d = EXPIRED;
          end else if (!Timer_Start) begin
            state_d = PAUSE;
          end
        end else if (!Timer_Start) begin
          state_d = PAUSE;
        end
      end

      PAUSE: begin
        if (Timer_Start) begin
          state_d = RUN;
        end
      end

      EXPIRED: begin
        tens_d = 4'd0;
        ones_d = 4'd0;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Flag outputs are derived from the next state/value so they line up
    // with the digits they describe.
    block_d = (state_d == EXPIRED);
    pulse_d = (state_d == EXPIRED) && (state_q != EXPIRED);
    val_d   = bcd_to_bin(tens_d, ones_d);
    warn_d  = ((state_d == RUN) || (state_d == PAUSE)) &&
              (val_d != 7'd0) && (val_d <= WARN_VAL);
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_q <= IDLE;
      tens_q  <= START_TENS;
      ones_q  <= START_ONES;
      block_q <= 1'b0;
      pulse_q <= 1'b0;
      warn_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
      block_q <= block_d;
      pulse_q <= pulse_d;
      warn_q  <= warn_d;
    end
  end

  assign Block_Sel     = block_q;
  assign Sec_Tens      = tens_q;
  assign Sec_Ones      = ones_q;
  assign Timeout_Pulse = pulse_q;
  assign Warn          = warn_q;

endmodule

// File: tb/tb_answer_timer.sv
// Directed bench for answer_timer. Four instances with different presets
// are exercised one after another from a single initial block.
//   a: CLK_HZ=4 START_SEC=3  WARN_SEC=1 - full run, expiry, lock, reset, tick/stop clash
//   b: CLK_HZ=4 START_SEC=12 WARN_SEC=0 - tens borrow 10 -> 09
//   c: CLK_HZ=4 START_SEC=5  WARN_SEC=2 - pause and resume from frozen prescaler
//   d: CLK_HZ=4 START_SEC=8  WARN_SEC=5 - warning window
module tb_answer_timer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstn_a, start_a, blk_a, pulse_a, warn_a;
  logic [3:0] tens_a, ones_a;
  logic       rstn_b, start_b, blk_b, pulse_b, warn_b;
  logic [3:0] tens_b, ones_b;
  logic       rstn_c, start_c, blk_c, pulse_c, warn_c;
  logic [3:0] tens_c, ones_c;
  logic       rstn_d, start_d, blk_d, pulse_d, warn_d;
  logic [3:0] tens_d, ones_d;

  answer_timer #(.CLK_HZ(4), .START_SEC(3), .WARN_SEC(1)) dut_a (
    .CLK(clk), .RSTn(rstn_a), .Timer_Start(start_a), .Block_Sel(blk_a),
    .Sec_Tens(tens_a), .Sec_Ones(ones_a), .Timeout_Pulse(pulse_a), .Warn(warn_a)
  );

  answer_timer #(.CLK_HZ(4), .START_SEC(12), .WARN_SEC(0)) dut_b (
    .CLK(clk), .RSTn(rstn_b), .Timer_Start(start_b), .Block_Sel(blk_b),
    .Sec_Tens(tens_b), .Sec_Ones(ones_b), .Timeout_Pulse(pulse_b), .Warn(warn_b)
  );

  answer_timer #(.CLK_HZ(4), .START_SEC(5), .WARN_SEC(2)) dut_c (
    .CLK(clk), .RSTn(rstn_c), .Timer_Start(start_c), .Block_Sel(blk_c),
    .Sec_Tens(tens_c), .Sec_Ones(ones_c), .Timeout_Pulse(pulse_c), .Warn(warn_c)
  );

  answer_timer #(.CLK_HZ(4), .START_SEC(8), .WARN_SEC(5)) dut_d (
    .CLK(clk), .RSTn(rstn_d), .Timer_Start(start_d), .Block_Sel(blk_d),
    .Sec_Tens(tens_d), .Sec_Ones(ones_d), .Timeout_Pulse(pulse_d), .Warn(warn_d)
  );

  int total  = 0;
  int passed = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance n rising edges, then settle 1 time unit past the last edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rstn_a = 1'b0; start_a = 1'b0;
    rstn_b = 1'b0; start_b = 1'b0;
    rstn_c = 1'b0; start_c = 1'b0;
    rstn_d = 1'b0; start_d = 1'b0;
    step(2);

    // Reset values
    chk("a_rst_dig",   {tens_a, ones_a}, 8'h03);
    chk("a_rst_blk",   blk_a,   1'b0);
    chk("a_rst_pulse", pulse_a, 1'b0);
    chk("a_rst_warn",  warn_a,  1'b0);
    chk("b_rst_dig",   {tens_b, ones_b}, 8'h12);
    chk("b_rst_flags", {blk_b, pulse_b, warn_b}, 3'b000);
    chk("c_rst_dig",   {tens_c, ones_c}, 8'h05);
    chk("c_rst_flags", {blk_c, pulse_c, warn_c}, 3'b000);
    chk("d_rst_dig",   {tens_d, ones_d}, 8'h08);
    chk("d_rst_flags", {blk_d, pulse_d, warn_d}, 3'b000);

    // a: full countdown 03 -> 00 in 12 cycles
    rstn_a = 1'b1; start_a = 1'b1;
    step(1);
    chk("a_e0_dig",  {tens_a, ones_a}, 8'h03);
    step(3);
    chk("a_e3_dig",  {tens_a, ones_a}, 8'h03);
    step(1);
    chk("a_e4_dig",  {tens_a, ones_a}, 8'h02);
    chk("a_e4_warn", warn_a, 1'b0);
    step(4);
    chk("a_e8_dig",  {tens_a, ones_a}, 8'h01);
    chk("a_e8_warn", warn_a, 1'b1);
    step(3);
    chk("a_e11_dig", {tens_a, ones_a}, 8'h01);
    chk("a_e11_blk", blk_a, 1'b0);
    step(1);
    chk("a_e12_dig",   {tens_a, ones_a}, 8'h00);
    chk("a_e12_blk",   blk_a,   1'b1);
    chk("a_e12_pulse", pulse_a, 1'b1);
    chk("a_e12_warn",  warn_a,  1'b0);
    step(1);
    chk("a_e13_pulse", pulse_a, 1'b0);
    chk("a_e13_blk",   blk_a,   1'b1);

    // a: Timer_Start ignored while expired
    start_a = 1'b0;
    step(2);
    start_a = 1'b1;
    step(2);
    chk("a_exp_dig",   {tens_a, ones_a}, 8'h00);
    chk("a_exp_blk",   blk_a,   1'b1);
    chk("a_exp_pulse", pulse_a, 1'b0);

    // a: one-cycle reset leaves expiry
    rstn_a = 1'b0;
    step(1);
    chk("a_rst2_dig", {tens_a, ones_a}, 8'h03);
    chk("a_rst2_blk", blk_a, 1'b0);
    rstn_a = 1'b1; start_a = 1'b0;
    step(2);
    chk("a_idle_dig", {tens_a, ones_a}, 8'h03);

    // a: Timer_Start drops in the tick cycle -> decrement, then frozen
    start_a = 1'b1;
    step(1);
    step(3);
    start_a = 1'b0;
    step(1);
    chk("a_clash_dig",  {tens_a, ones_a}, 8'h02);
    step(10);
    chk("a_clash_hold", {tens_a, ones_a}, 8'h02);
    start_a = 1'b1;
    step(1);
    step(3);
    chk("a_res_e3_dig", {tens_a, ones_a}, 8'h02);
    step(1);
    chk("a_res_e4_dig",  {tens_a, ones_a}, 8'h01);
    chk("a_res_e4_warn", warn_a, 1'b1);
    start_a = 1'b0;
    step(2);
    chk("a_pause_warn", warn_a, 1'b1);
    chk("a_pause_dig",  {tens_a, ones_a}, 8'h01);

    // b: tens borrow
    rstn_b = 1'b1; start_b = 1'b1;
    step(1);
    chk("b_e0_dig",  {tens_b, ones_b}, 8'h12);
    step(4);
    chk("b_e4_dig",  {tens_b, ones_b}, 8'h11);
    step(4);
    chk("b_e8_dig",  {tens_b, ones_b}, 8'h10);
    step(4);
    chk("b_e12_dig", {tens_b, ones_b}, 8'h09);
    chk("b_e12_warn", warn_b, 1'b0);
    start_b = 1'b0;

    // c: pause after 6 run cycles, resume 20 cycles later
    rstn_c = 1'b1; start_c = 1'b1;
    step(1);
    step(6);
    chk("c_run6_dig", {tens_c, ones_c}, 8'h04);
    start_c = 1'b0;
    step(10);
    chk("c_pause10_dig", {tens_c, ones_c}, 8'h04);
    step(10);
    chk("c_pause20_dig", {tens_c, ones_c}, 8'h04);
    chk("c_pause_flags", {blk_c, pulse_c, warn_c}, 3'b000);
    start_c = 1'b1;
    step(1);
    chk("c_res0_dig", {tens_c, ones_c}, 8'h04);
    step(1);
    chk("c_res1_dig", {tens_c, ones_c}, 8'h04);
    step(1);
    chk("c_res2_dig", {tens_c, ones_c}, 8'h03);
    start_c = 1'b0;

    // d: warning window 05..01
    rstn_d = 1'b1; start_d = 1'b1;
    step(1);
    for (int k = 0; k <= 8; k++) begin
      if (k > 0) step(4);
      chk($sformatf("d_dig_%0d", 8 - k), {tens_d, ones_d}, 32'(8 - k));
      chk($sformatf("d_warn_%0d", 8 - k), warn_d, ((8 - k) >= 1 && (8 - k) <= 5) ? 1'b1 : 1'b0);
    end
    chk("d_end_blk",   blk_d,   1'b1);
    chk("d_end_pulse", pulse_d, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/answer_timer.md
# answer_timer

Countdown timer for the quiz responder. Consumes `Timer_Start` from the player-select stage, counts seconds down from a preset in BCD, and drives `Block_Sel` back to the select stage when time expires, which locks out further key presses. It also drives the two-digit countdown display and a last-seconds warning for the buzzer mux.

## Interface
- `CLK_HZ`, default 50_000_000: `CLK` frequency. One second is CLK_HZ cycles. Legal range is 2 and up.
- `START_SEC`, default 30: countdown preload. Legal range is 1..99.
- `WARN_SEC`, default 5: `Warn` is asserted while the remaining value is 1..WARN_SEC. Legal range is 0..START_SEC.
- `CLK  in  1` — system clock, single clock domain.
- `RSTn  in  1` — reset, synchronous and active-low.
- `Timer_Start  in  1` — level input. 1 means count; 0 means hold.
- `Block_Sel  out  1` — 1 means time has expired and the select stage must ignore keys.
- `Sec_Tens  out  4` — BCD tens digit of remaining seconds.
- `Sec_Ones  out  4` — BCD ones digit of remaining seconds.
- `Timeout_Pulse  out  1` — one-cycle strobe on expiry.
- `Warn  out  1` — final-seconds warning level.

## Operation
- State machine: IDLE, RUN, PAUSE, EXPIRED. All transitions are evaluated on `posedge CLK`.
- IDLE
  - Digits hold START_SEC and the prescaler is 0.
  - `Timer_Start`=1 moves to RUN.
- RUN
  - The prescaler counts 0..CLK_HZ-1. The cycle where it equals CLK_HZ-1 is a tick, and the prescaler wraps to 0.
  - On a tick the BCD value decrements. If ones=0, ones becomes 9 and tens decrements; otherwise ones decrements.
  - A tick that takes the value to 00 moves to EXPIRED.
  - `Timer_Start`=0 moves to PAUSE.
- PAUSE (a player answered)
  - The prescaler and digits freeze.
  - `Timer_Start`=1 returns to RUN and resumes from the frozen prescaler value, with no reload.
- EXPIRED
  - Digits hold 00 and `Block_Sel`=1.
  - `Timer_Start` is ignored.
  - Only reset leaves this state.
- Simultaneous tick and `Timer_Start` falling in the same RUN cycle: the tick wins. The decrement is applied, and the machine enters PAUSE (or EXPIRED, if the value reached 00) in that same cycle.
- The digits never underflow below 00. The tens digit never exceeds 9.
- `Warn` = (state==RUN or PAUSE) and 1 ≤ value ≤ WARN_SEC.
- Reset, including mid-count or in EXPIRED:
  - state=IDLE, prescaler=0, digits=START_SEC.
  - `Block_Sel`=0, `Timeout_Pulse`=0, `Warn`=0.

## Timing
- All outputs are registered.
- Reset values:
  - `Block_Sel`=0, `Timeout_Pulse`=0, `Warn`=0.
  - `Sec_Tens`=START_SEC/10, `Sec_Ones`=START_SEC%10.
- Start latency:
  - `Timer_Start` is sampled high at edge E0, and the state is RUN after E0.
  - The first tick occurs CLK_HZ cycles later, and the first decrement is visible after edge E0+CLK_HZ.
- Expiry:
  - The tick edge that writes 00 also sets `Block_Sel`=1 and `Timeout_Pulse`=1. Both are visible in the same cycle as digits 00.
  - `Timeout_Pulse` returns to 0 on the next edge.
- Pause latency: `Timer_Start` sampled low at edge E freezes the counters from edge E onward, so no further prescaler increment occurs.
- Total run time from start to expiry is START_SEC × CLK_HZ cycles, excluding paused cycles.

## Structure
- Shared package `responder_pkg`:
  - `timer_state_t` enum (IDLE, RUN, PAUSE, EXPIRED).
  - `bcd_digit_t` (4-bit).
  - The BCD max-digit constant 9.
- Sub-module `tick_gen`:
  - Parameter CLK_HZ, inputs `en` and `clr`, output `tick`.
  - Prescaler counter of width $clog2(CLK_HZ).
  - Instantiated once.
- The BCD decrement and FSM live in `answer_timer`.

## Test plan
- CLK_HZ=4, START_SEC=3. After reset, hold `Timer_Start`=1 → digits go 03, 02, 01, 00 at 4-cycle intervals. `Block_Sel` and `Timeout_Pulse` rise with 00; the pulse lasts exactly 1 cycle; total time 12 cycles.
- CLK_HZ=4, START_SEC=12. Run until 10 → next tick gives 09 (ones wraps to 9, tens goes 1→0).
- CLK_HZ=4, START_SEC=5. Run 6 cycles, drop `Timer_Start` for 20 cycles, then raise it again → digits frozen at 04 during the pause; the next tick arrives 2 cycles after resume.
- Tick cycle coincides with `Timer_Start` falling → the decrement is applied and the state is PAUSE with no further change.
- In EXPIRED, toggle `Timer_Start` → no change. Pulse `RSTn`=0 for 1 cycle → digits return to START_SEC and `Block_Sel`=0.
- CLK_HZ=4, START_SEC=8, WARN_SEC=5 → `Warn` is 0 at 08..06, 1 at 05..01, and 0 at 00.
